// File: rtl/mul_seq_32bit_pkg.sv
// Shared constants and state encoding for the sequential 32x32 shift-add multiplier.
package mul_seq_32bit_pkg;
   localparam int MUL_WIDTH = 32;
   localparam int CNT_W     = 6;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/full_adder_32bit.sv
// 32-bit adder with carry in/out; the only arithmetic on the multiplier datapath.
module full_adder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        c_in,
   output logic [31:0] sum,
   output logic        c_out
);
   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
endmodule

// File: rtl/mul_seq_32bit.sv
// Unsigned 32x32 sequential multiplier, one shift-add step per clock, done 32 cycles after start.
//
// state | meaning
// IDLE  | waiting for start, product held
// RUN   | 32 shift-add steps, counter tracks step index
// DONE  | product valid, done pulse for one cycle
module mul_seq_32bit
   import mul_seq_32bit_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] mcand, acc_hi, acc_lo, addend, sum;
   logic             carry;
   logic             last_step;

   assign addend    = acc_lo[0] ? mcand : '0;
   assign last_step = (cnt == LAST_STEP);

   full_adder_32bit u_add (
      .a     (acc_hi),
      .b     (addend),
      .c_in  (1'b0),
      .sum   (sum),
      .c_out (carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (last_step) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         mcand   <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         product <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               mcand  <= a;
               acc_lo <= b;
               acc_hi <= '0;
               cnt    <= '0;
            end
            ST_RUN: begin
               // {carry, sum, acc_lo} shifted right by one
               acc_hi <= {carry, sum[WIDTH-1:1]};
               acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
               cnt    <= cnt + 1'b1;
               if (last_step) product <= {carry, sum, acc_lo[WIDTH-1:1]};
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_seq_32bit.sv
// Directed bench for mul_seq_32bit: latency, products, ignored start, reset abort, back-to-back.
module tb_mul_seq_32bit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [63:0] product;

   int n_checks = 0;
   int n_fail   = 0;

   mul_seq_32bit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulses start for one edge, then counts edges until done (bounded).
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] exp);
      int cyc;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      cyc = 0;
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'd32);
      check({tag, "_product"}, product, exp);
      @(posedge clk); #1;
      check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      int cyc, n_done, d1, d2;
      logic [63:0] p1, p2;

      #1;
      check("reset_outputs", {busy, done, product}, 66'd0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", {busy, done, product}, 66'd0);
      @(negedge clk); rst = 1'b0;

      run_op("mul_3x5", 32'd3, 32'd5, 64'd15);
      repeat (3) @(posedge clk);
      #1;
      check("product_hold", product, 64'd15);

      run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_op("mul_2p16", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
      run_op("mul_zero_a", 32'd0, 32'hDEAD_BEEF, 64'd0);
      run_op("mul_zero_b", 32'h1234_5678, 32'd0, 64'd0);
      run_op("mul_mixed", 32'h8000_0001, 32'd3, 64'h0000_0001_8000_0003);

      // start ignored mid-run, operand changes ignored
      @(negedge clk);
      a = 32'd7; b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0; n_done = 0; d1 = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 10) begin
            @(negedge clk);
            a = 32'd2; b = 32'd2; start = 1'b1;
         end else if (i == 11) begin
            @(negedge clk);
            start = 1'b0; a = 32'h55; b = 32'hAA;
         end
         @(posedge clk); #1;
         if (done) begin
            n_done++;
            d1 = i;
            check("ignore_start_product", product, 64'd42);
         end
      end
      check("ignore_start_ndone", 64'(n_done), 64'd1);
      check("ignore_start_cycle", 64'(d1), 64'd32);

      // reset mid-run aborts with no done
      @(negedge clk);
      a = 32'd100; b = 32'd100; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_outputs", {busy, done, product}, 66'd0);
      @(negedge clk); rst = 1'b0;
      n_done = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("abort_no_done", 64'(n_done), 64'd0);
      run_op("mul_9x9", 32'd9, 32'd9, 64'd81);

      // start held high: back-to-back operations
      @(negedge clk);
      a = 32'd2; b = 32'd3; start = 1'b1;
      n_done = 0; d1 = 0; d2 = 0; p1 = '1; p2 = '1;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk); #1;
         if (done) begin
            n_done++;
            if (n_done == 1) begin d1 = i; p1 = product; end
            else if (n_done == 2) begin d2 = i; p2 = product; end
         end
      end
      start = 1'b0;
      check("b2b_ndone", 64'(n_done), 64'd2);
      check("b2b_spacing", 64'(d2 - d1), 64'd34);
      check("b2b_product1", p1, 64'd6);
      check("b2b_product2", p2, 64'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
